fdivsqrt_iter_ctrl: RTL and testbench

//  Sequencer for the radix-4 divide/sqrt recurrence (fdivsqrtstage4 chain).

---
 rtl/fdivsqrt_iter_ctrl_pkg.sv | 17 +
 rtl/fdivsqrt_iter_ctrl_if.sv | 29 ++
 rtl/fdivsqrt_iter_ctrl_step_counter.sv | 39 +++
 rtl/fdivsqrt_iter_ctrl.sv | 104 ++++++++++
 tb/tb_fdivsqrt_iter_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fdivsqrt_iter_ctrl_pkg.sv
// Shared types for the radix-4 divide/sqrt iteration sequencer: the configuration
// record and the FSM state encoding.
package fdivsqrt_iter_ctrl_pkg;

    typedef struct packed {
        int unsigned DURLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{DURLEN: 32'd6};

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } divstate_t;

endpackage

// File: rtl/fdivsqrt_iter_ctrl_if.sv
// E-stage <-> divide/sqrt sequencer control bundle. The pipeline side is the master,
// the sequencer is the slave.
interface fdivsqrt_iter_ctrl_if #(parameter int DURLEN = 6);

    logic              FDivStartE;
    logic              SqrtE;
    logic              SpecialCaseE;
    logic [DURLEN-1:0] CyclesE;
    logic              WZeroE;
    logic              StallM;
    logic              FlushE;

    logic              IFDivStartE;
    logic              j1;
    logic              jlast;
    logic              FDivBusyE;
    logic              FDivDoneE;

    modport master (
        output FDivStartE, SqrtE, SpecialCaseE, CyclesE, WZeroE, StallM, FlushE,
        input  IFDivStartE, j1, jlast, FDivBusyE, FDivDoneE
    );

    modport slave (
        input  FDivStartE, SqrtE, SpecialCaseE, CyclesE, WZeroE, StallM, FlushE,
        output IFDivStartE, j1, jlast, FDivBusyE, FDivDoneE
    );

endinterface

// File: rtl/fdivsqrt_iter_ctrl_step_counter.sv
// Loadable down-counter for the remaining recurrence steps. A load of zero is
// promoted to one so every iterated operation runs at least one step.
module fdivsqrt_step_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic         clr,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         is_one
);

    logic [W-1:0] count_d, count_q;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val == '0) ? W'(1) : load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count  = count_q;
    assign is_one = (count_q == W'(1));

endmodule

// File: rtl/fdivsqrt_iter_ctrl.sv
// Sequencer for the radix-4 divide/sqrt recurrence: accepts a start, runs the
// programmed number of steps, drives j1/jlast/initialise strobes, busy and done.
module fdivsqrt_iter_ctrl
    import fdivsqrt_iter_ctrl_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    fdivsqrt_iter_ctrl_if.slave  bus
);

    localparam int DURLEN = int'(P.DURLEN);

    divstate_t         state_d, state_q;
    logic              j1_flag_d, j1_flag_q;
    logic              cnt_load, cnt_dec, cnt_clr;
    logic              step_one;
    logic [DURLEN-1:0] step;
    logic              start_ok;

    logic              ifdiv_start, j1, jlast;

    assign start_ok = bus.FDivStartE & ~bus.FlushE;

    fdivsqrt_step_counter #(.W(DURLEN)) u_step_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .clr      (cnt_clr),
        .load_val (bus.CyclesE),
        .count    (step),
        .is_one   (step_one)
    );

    always_comb begin
        state_d     = state_q;
        j1_flag_d   = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_clr     = 1'b0;
        ifdiv_start = 1'b0;
        j1          = 1'b0;
        jlast       = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (start_ok) begin
                    if (bus.SpecialCaseE) begin
                        state_d = DIV_DONE;
                    end else begin
                        state_d     = DIV_BUSY;
                        ifdiv_start = 1'b1;
                        cnt_load    = 1'b1;
                        j1_flag_d   = 1'b1;
                    end
                end
            end
            DIV_BUSY: begin
                if (bus.FlushE) begin
                    state_d = DIV_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    j1    = j1_flag_q & bus.SqrtE;
                    jlast = step_one;
                    // A zero residual ends a divide early; sqrt must still run every step.
                    if (step_one || (bus.WZeroE && !bus.SqrtE)) begin
                        state_d = DIV_DONE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_dec = (step != '0);
                    end
                end
            end
            DIV_DONE: begin
                if (bus.FlushE || !bus.StallM) state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DIV_IDLE;
            j1_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            j1_flag_q <= j1_flag_d;
        end
    end

    assign bus.IFDivStartE = ifdiv_start;
    assign bus.j1          = j1;
    assign bus.jlast       = jlast;
    assign bus.FDivDoneE   = (state_q == DIV_DONE);
    assign bus.FDivBusyE   = ((state_q == DIV_IDLE) & start_ok & ~bus.SpecialCaseE)
                           | (state_q == DIV_BUSY)
                           | ((state_q == DIV_DONE) & bus.StallM);

endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// Self-checking bench for fdivsqrt_iter_ctrl: table of per-operation scenarios with
// expected strobe timing, scoreboarded per start, plus reset corner sequences.
module tb_fdivsqrt_iter_ctrl;
    import fdivsqrt_iter_ctrl_pkg::*;

    localparam int WIN = 72;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fdivsqrt_iter_ctrl_if #(.DURLEN(6)) bus ();

    fdivsqrt_iter_ctrl #(.P(CVW_DEFAULT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit sqrt;
        bit special;
        int cycles;
        int wzero_at;
        int flush_at;
        int stall_lo;
        int stall_hi;
        int e_done_first;
        int e_done_cnt;
        int e_jlast_first;
        int e_jlast_cnt;
        int e_j1_first;
        int e_j1_cnt;
        int e_busy_cnt;
        int e_ifs_cnt;
    } vec_t;

    vec_t vecs[11];
    vec_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.FDivStartE   = 1'b0;
        bus.SqrtE        = 1'b0;
        bus.SpecialCaseE = 1'b0;
        bus.CyclesE      = '0;
        bus.WZeroE       = 1'b0;
        bus.StallM       = 1'b0;
        bus.FlushE       = 1'b0;
    endtask

    function automatic int outs();
        return {27'd0, bus.IFDivStartE, bus.j1, bus.jlast, bus.FDivBusyE, bus.FDivDoneE};
    endfunction

    // Runs one operation starting now (posedge+1); cycle 0 is the start cycle.
    task automatic run_vec(input int idx, input vec_t v);
        int done_first = -1, done_cnt = 0;
        int jl_first = -1, jl_cnt = 0;
        int j1_first = -1, j1_cnt = 0;
        int busy_cnt = 0, ifs_cnt = 0;
        int last_outs = 0;
        vec_t e;
        for (int c = 0; c < WIN; c++) begin
            bus.FDivStartE   = (c == 0);
            bus.SqrtE        = v.sqrt;
            bus.SpecialCaseE = v.special;
            bus.CyclesE      = 6'(v.cycles);
            bus.WZeroE       = (c == v.wzero_at);
            bus.StallM       = (c >= v.stall_lo) && (c <= v.stall_hi);
            bus.FlushE       = (c == v.flush_at);
            if (c == 0) sb_q.push_back(v);
            @(negedge clk);
            if (bus.FDivDoneE)   begin if (done_first < 0) done_first = c; done_cnt++; end
            if (bus.jlast)       begin if (jl_first < 0) jl_first = c; jl_cnt++; end
            if (bus.j1)          begin if (j1_first < 0) j1_first = c; j1_cnt++; end
            if (bus.FDivBusyE)   busy_cnt++;
            if (bus.IFDivStartE) ifs_cnt++;
            last_outs = outs();
            @(posedge clk);
            #1;
        end
        idle_inputs();
        check($sformatf("v%0d_sb_nonempty", idx), int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("v%0d_done_first", idx), done_first, e.e_done_first);
            check($sformatf("v%0d_done_cnt", idx),   done_cnt,   e.e_done_cnt);
            check($sformatf("v%0d_jlast_first", idx), jl_first,  e.e_jlast_first);
            check($sformatf("v%0d_jlast_cnt", idx),  jl_cnt,     e.e_jlast_cnt);
            check($sformatf("v%0d_j1_first", idx),   j1_first,   e.e_j1_first);
            check($sformatf("v%0d_j1_cnt", idx),     j1_cnt,     e.e_j1_cnt);
            check($sformatf("v%0d_busy_cnt", idx),   busy_cnt,   e.e_busy_cnt);
            check($sformatf("v%0d_ifdivstart_cnt", idx), ifs_cnt, e.e_ifs_cnt);
        end
        check($sformatf("v%0d_idle_at_end", idx), last_outs, 0);
    endtask

    initial begin
        int done_seen;

        //          sq sp cyc wz  fl  stl stH  dF dC  jlF jlC j1F j1C bsy ifs
        vecs[0]  = '{0, 0,  5, -1, -1, -1, -1,  6, 1,   5, 1, -1, 0,  6, 1}; // divide, 5 steps
        vecs[1]  = '{1, 0,  3, -1, -1, -1, -1,  4, 1,   3, 1,  1, 1,  4, 1}; // sqrt, 3 steps
        vecs[2]  = '{0, 1,  5, -1, -1, -1, -1,  1, 1,  -1, 0, -1, 0,  0, 0}; // special case
        vecs[3]  = '{0, 0,  8,  3, -1, -1, -1,  4, 1,  -1, 0, -1, 0,  4, 1}; // early exit on zero residual
        vecs[4]  = '{0, 0,  6, -1,  2, -1, -1, -1, 0,  -1, 0, -1, 0,  3, 1}; // flush in 2nd busy cycle
        vecs[5]  = '{0, 0,  2, -1, -1,  3,  5,  3, 4,   2, 1, -1, 0,  6, 1}; // done held by StallM
        vecs[6]  = '{0, 0,  0, -1, -1, -1, -1,  2, 1,   1, 1, -1, 0,  2, 1}; // zero cycles acts as one
        vecs[7]  = '{1, 0,  4,  2, -1, -1, -1,  5, 1,   4, 1,  1, 1,  5, 1}; // sqrt ignores WZeroE
        vecs[8]  = '{0, 0,  3, -1,  0, -1, -1, -1, 0,  -1, 0, -1, 0,  0, 0}; // flush on start cycle
        vecs[9]  = '{1, 0,  1, -1, -1, -1, -1,  2, 1,   1, 1,  1, 1,  2, 1}; // sqrt single step: j1 and jlast
        vecs[10] = '{0, 0, 63, -1, -1, -1, -1, 64, 1,  63, 1, -1, 0, 64, 1}; // max step count

        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", outs(), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", outs(), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of a sqrt: operation abandoned, no done pulse.
        bus.FDivStartE = 1'b1;
        bus.SqrtE      = 1'b1;
        bus.CyclesE    = 6'd6;
        @(negedge clk);
        check("rst_mid_start_ifdiv", int'(bus.IFDivStartE), 1);
        @(posedge clk);
        #1;
        bus.FDivStartE = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", int'(bus.FDivBusyE), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", outs(), 0);
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (bus.FDivDoneE || bus.FDivBusyE || bus.jlast) done_seen++;
        end
        check("rst_mid_no_done", done_seen, 0);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
